// File: rtl/unidade_busca_pkg.sv
// Shared widths, FSM state codes and step-counter codes for the fetch unit.
package unidade_busca_pkg;
  localparam int WORD_W  = 16;
  localparam int INSTR_W = 9;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;
  localparam logic [1:0] T3 = 2'b11;
endpackage

// File: rtl/contador_2bits.sv
// Two-bit step counter: synchronous clear wins over enable, wraps 3 -> 0.
module contador_2bits
  import unidade_busca_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Clear,
  input  logic       En,
  output logic [1:0] Q
);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      Q <= T0;
    end else if (Clear) begin
      Q <= T0;
    end else if (En) begin
      Q <= Q + 2'd1;
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: IDLE/EXEC sequencer, PC/ADDR/IR registers,
// retired-instruction counter and sticky step-overflow flag.
module unidade_busca
  import unidade_busca_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Run,
  input  logic                 Clear,
  input  logic                 Done,
  input  logic                 IncrPc,
  input  logic                 ADDRin,
  input  logic                 IRin,
  input  logic                 PCin,
  input  logic [WORD_W-1:0]    BusWires,
  input  logic [WORD_W-1:0]    DIN,
  output logic [INSTR_W-1:0]   Instrucao,
  output logic [1:0]           Tstep,
  output logic [WORD_W-1:0]    PC,
  output logic [WORD_W-1:0]    ADDR,
  output logic                 Busy,
  output logic [WORD_W-1:0]    InstrCount,
  output logic                 StepOvf
);

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic               run_prev;
  logic               run_armed;
  logic               exec;
  logic               start;
  logic               cnt_clear;
  logic [INSTR_W-1:0] ir;
  logic               unused_din;

  assign exec = (state == EXEC);

  // run_armed stays low after reset until Run is seen low, so a Run held
  // high through reset cannot masquerade as a rising edge.
  assign start = Run & ~run_prev & run_armed;

  always_comb begin
    state_next = state;
    if (!exec) begin
      if (start) state_next = EXEC;
    end else if (Done && !Run) begin
      state_next = IDLE;
    end
  end

  // Counter is held at T0 whenever the next state is IDLE.
  assign cnt_clear = ~exec | Clear | (Done & ~Run);

  contador_2bits u_step (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Clear  (cnt_clear),
    .En     (exec),
    .Q      (Tstep)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= IDLE;
      Busy       <= 1'b0;
      run_prev   <= 1'b0;
      run_armed  <= 1'b0;
      PC         <= '0;
      ADDR       <= '0;
      ir         <= '0;
      InstrCount <= '0;
      StepOvf    <= 1'b0;
    end else begin
      state    <= state_next;
      Busy     <= (state_next == EXEC);
      run_prev <= Run;
      if (!Run) run_armed <= 1'b1;
      if (exec) begin
        if (Done) InstrCount <= InstrCount + 16'd1;
        if (Tstep == T3 && !Clear) StepOvf <= 1'b1;
        // ADDR captures the pre-update PC.
        if (ADDRin) ADDR <= PC;
        if (PCin) begin
          PC <= BusWires;
        end else if (IncrPc) begin
          PC <= PC + 16'd1;
        end
        if (IRin) ir <= DIN[INSTR_W-1:0];
      end
    end
  end

  assign Instrucao  = ir;
  assign unused_din = ^DIN[WORD_W-1:INSTR_W];

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed scenarios plus random traffic, each cycle
// compared against a behavioural model of the fetch unit.
module tb_unidade_busca;

  logic        clock;
  logic        resetn;
  logic        run;
  logic        clear;
  logic        done;
  logic        incr_pc;
  logic        addr_in;
  logic        ir_in;
  logic        pc_in;
  logic [15:0] bus_wires;
  logic [15:0] din;
  logic [8:0]  instrucao;
  logic [1:0]  tstep;
  logic [15:0] pc;
  logic [15:0] addr;
  logic        busy;
  logic [15:0] instr_count;
  logic        step_ovf;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  bit          m_busy;
  int          m_tstep;
  logic [15:0] m_pc, m_addr, m_cnt;
  logic [8:0]  m_ir;
  bit          m_ovf;
  bit          m_run_last;
  bit          m_seen_low;

  unidade_busca dut (
    .Clock      (clock),
    .Resetn     (resetn),
    .Run        (run),
    .Clear      (clear),
    .Done       (done),
    .IncrPc     (incr_pc),
    .ADDRin     (addr_in),
    .IRin       (ir_in),
    .PCin       (pc_in),
    .BusWires   (bus_wires),
    .DIN        (din),
    .Instrucao  (instrucao),
    .Tstep      (tstep),
    .PC         (pc),
    .ADDR       (addr),
    .Busy       (busy),
    .InstrCount (instr_count),
    .StepOvf    (step_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], ~a[7:0]} ^ 16'h5a3c;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies the rules to the inputs present at the clock edge.
  task automatic model_step();
    bit rising;
    if (!resetn) begin
      m_busy = 0; m_tstep = 0; m_pc = 0; m_addr = 0; m_ir = 0;
      m_cnt = 0; m_ovf = 0; m_run_last = 0; m_seen_low = 0;
      return;
    end
    rising = run && !m_run_last && m_seen_low;
    if (m_busy) begin
      if (m_tstep == 3 && !clear) m_ovf = 1;
      if (done) m_cnt = m_cnt + 16'd1;
      if (addr_in) m_addr = m_pc;
      if (pc_in) m_pc = bus_wires;
      else if (incr_pc) m_pc = m_pc + 16'd1;
      if (ir_in) m_ir = din[8:0];
      if (done && !run) begin
        m_busy = 0;
        m_tstep = 0;
      end else if (clear) begin
        m_tstep = 0;
      end else begin
        m_tstep = (m_tstep + 1) % 4;
      end
    end else begin
      m_tstep = 0;
      if (rising) m_busy = 1;
    end
    if (!run) m_seen_low = 1;
    m_run_last = run;
  endtask

  task automatic check_all();
    chk("busy",       16'(busy),        16'(m_busy));
    chk("tstep",      16'(tstep),       16'(m_tstep));
    chk("pc",         pc,               m_pc);
    chk("addr",       addr,             m_addr);
    chk("instrucao",  16'(instrucao),   16'(m_ir));
    chk("instrcount", instr_count,      m_cnt);
    chk("stepovf",    16'(step_ovf),    16'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    clear = 0; done = 0; incr_pc = 0; addr_in = 0; ir_in = 0; pc_in = 0;
    bus_wires = 16'h0000; din = 16'h0000;
  endtask

  initial begin
    logic [15:0] p;
    resetn = 0; run = 0;
    idle_inputs();
    m_busy = 0; m_tstep = 0; m_pc = 0; m_addr = 0; m_ir = 0;
    m_cnt = 0; m_ovf = 0; m_run_last = 0; m_seen_low = 0;

    // Reset state
    tick(); tick();
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_pc", pc, 16'h0000);
    resetn = 1;
    tick();

    // Run 0->1 then free-running step counter with wrap
    run = 1;
    tick();
    chk("start_busy", 16'(busy), 16'd1);
    chk("start_tstep", 16'(tstep), 16'd0);
    tick(); chk("t1", 16'(tstep), 16'd1);
    tick(); chk("t2", 16'(tstep), 16'd2);
    tick(); chk("t3", 16'(tstep), 16'd3);
    chk("ovf_before_wrap", 16'(step_ovf), 16'd0);
    tick(); chk("wrap_t0", 16'(tstep), 16'd0);
    chk("ovf_after_wrap", 16'(step_ovf), 16'd1);

    // ADDR takes pre-increment PC
    pc_in = 1; bus_wires = 16'h0005; tick(); pc_in = 0;
    addr_in = 1; incr_pc = 1; tick(); addr_in = 0; incr_pc = 0;
    chk("addr_pre_inc", addr, 16'h0005);
    chk("pc_inc", pc, 16'h0006);

    // PC wrap and PCin priority
    pc_in = 1; bus_wires = 16'hffff; tick(); pc_in = 0;
    incr_pc = 1; tick();
    chk("pc_wrap", pc, 16'h0000);
    pc_in = 1; bus_wires = 16'h0042; tick(); pc_in = 0; incr_pc = 0;
    chk("pcin_priority", pc, 16'h0042);

    // IR load, discarding upper DIN bits
    din = 16'hfe00 | 16'h01cb; ir_in = 1; tick(); ir_in = 0;
    chk("ir_load", 16'(instrucao), 16'h01cb);

    // ADDR -> memory -> IR latency chain
    p = m_pc;
    addr_in = 1; tick(); addr_in = 0;
    din = mem_word(addr); tick();
    ir_in = 1; tick(); ir_in = 0;
    chk("fetch_chain", 16'(instrucao), 16'(mem_word(p) & 16'h01ff));
    din = 16'h01cb; ir_in = 1; tick(); ir_in = 0;

    // Done with Clear, Run high then low
    done = 1; clear = 1; tick();
    chk("done_cnt1", instr_count, 16'd1);
    chk("done_stay_busy", 16'(busy), 16'd1);
    chk("done_tstep", 16'(tstep), 16'd0);
    run = 0; tick(); done = 0; clear = 0;
    chk("done_idle_busy", 16'(busy), 16'd0);
    chk("done_cnt2", instr_count, 16'd2);

    // Controls ignored in IDLE
    din = 16'h00aa; ir_in = 1; incr_pc = 1; done = 1; tick();
    idle_inputs();
    chk("idle_ir_hold", 16'(instrucao), 16'h01cb);
    chk("idle_cnt_hold", instr_count, 16'd2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      resetn    = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 7) == 0) run = ~run;
      done      = ($urandom_range(0, 5) == 0);
      clear     = ($urandom_range(0, 3) == 0);
      incr_pc   = $urandom_range(0, 1);
      addr_in   = $urandom_range(0, 1);
      ir_in     = $urandom_range(0, 1);
      pc_in     = ($urandom_range(0, 3) == 0);
      bus_wires = 16'($urandom);
      din       = $urandom_range(0, 1) ? mem_word(m_addr) : 16'($urandom);
      tick();
    end

    // Reset mid-instruction, then Run held high must not restart
    resetn = 1; run = 0; idle_inputs(); tick(); tick();
    run = 1; tick();
    pc_in = 1; bus_wires = 16'h0010; tick(); pc_in = 0;
    tick();
    chk("pre_reset_tstep", 16'(tstep), 16'd2);
    chk("pre_reset_pc", pc, 16'h0010);
    resetn = 0; done = 1; clear = 1; incr_pc = 1; addr_in = 1; ir_in = 1; pc_in = 1;
    bus_wires = 16'hbeef; din = 16'hffff;
    tick();
    idle_inputs();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_ir", 16'(instrucao), 16'h0000);
    chk("rst_tstep", 16'(tstep), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    resetn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_held_no_start", 16'(busy), 16'd0);
    end
    run = 0; tick();
    run = 1; tick();
    chk("restart_busy", 16'(busy), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; all state changes occur on the rising edge of Clock.
REQ-002 The block SHALL have these ports:
- Clock: in, 1 bit, processor clock.
- Resetn: in, 1 bit, synchronous reset, active-low.
- Run: in, 1 bit, start request; level-sensitive, edge-detected internally.
- Clear: in, 1 bit, from the control unit; restarts the step counter.
- Done: in, 1 bit, from the control unit; the current instruction has retired.
- IncrPc: in, 1 bit, increments PC.
- ADDRin: in, 1 bit, loads ADDR from PC.
- IRin: in, 1 bit, loads IR from DIN.
- PCin: in, 1 bit, loads PC from BusWires.
- BusWires: in, 16 bits, processor bus.
- DIN: in, 16 bits, memory read data, valid one cycle after ADDR changes.
- Instrucao: out, 9 bits, IR contents, fed to the control unit.
- Tstep: out, 2 bits, step counter value: 00=T0, 01=T1, 10=T2, 11=T3.
- PC: out, 16 bits, program counter.
- ADDR: out, 16 bits, memory address register.
- Busy: out, 1 bit, high while the state is EXEC.
- InstrCount: out, 16 bits, count of retired instructions.
- StepOvf: out, 1 bit, sticky flag set when Tstep wraps without a Clear.

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and EXEC.
REQ-004 In IDLE, Tstep SHALL be held at 00.
REQ-005 On the first Run=1 after Run=0 (rising edge, registered previous value), IDLE SHALL go to EXEC with Tstep=00 on the next cycle.
REQ-006 In EXEC, Tstep SHALL advance by 1 each cycle unless Clear=1; Clear=1 SHALL force Tstep to 00 on the next cycle.
REQ-007 If Tstep=11 and Clear=0, Tstep SHALL wrap to 00 and StepOvf SHALL set and stay set until reset.
REQ-008 When Done=1 in EXEC, InstrCount SHALL increment by 1, wrapping from FFFF to 0000.
REQ-009 On Done=1, if Run=1 the state SHALL stay EXEC; if Run=0 the state SHALL go to IDLE.
REQ-010 Done, Clear, IncrPc, ADDRin, IRin and PCin SHALL be ignored while in IDLE.
REQ-011 IncrPc=1 SHALL set PC to PC+1, modulo 2^16; FFFF wraps to 0000.
REQ-012 PCin=1 SHALL load PC from BusWires and SHALL take priority over IncrPc.
REQ-013 ADDRin=1 SHALL load ADDR with the PC value before any same-cycle update from IncrPc or PCin.
REQ-014 IRin=1 SHALL load IR with DIN[8:0]; DIN[15:9] is discarded.
REQ-015 Instrucao SHALL equal IR and SHALL change only on IRin.
REQ-016 Latency: ADDRin at cycle n gives ADDR at n+1; memory gives DIN at n+2; IRin at n+2 gives Instrucao at n+3.
REQ-017 A Run rising edge while already in EXEC SHALL have no effect.
REQ-018 Busy SHALL be a registered output equal to (state==EXEC).

Reset
REQ-019 Resetn=0 at a clock edge SHALL set:
- PC, ADDR, IR and InstrCount to 0.
- Tstep to 00, StepOvf to 0.
- Run edge register to 0.
- state to IDLE, so Busy=0.
REQ-020 Reset SHALL override every other input in the same cycle, including a reset mid-instruction at any Tstep.
REQ-021 After Resetn returns high, Run already high SHALL NOT start execution; Run must first be seen low.

Structure
REQ-022 A shared package SHALL hold:
- WORD_W=16 and INSTR_W=9.
- the state encoding: IDLE=0, EXEC=1.
- the Tstep codes T0 to T3.
REQ-023 The step counter SHALL be the sub-module contador_2bits, with Clock, Resetn, Clear, En and Q ports.
REQ-024 All other registers SHALL be implemented in unidade_busca itself.

Verification
REQ-025 Reset, then Run 0->1: Busy=1 after 1 cycle, Tstep=00; with no Clear, Tstep runs 01, 10, 11, 00, and StepOvf=1 after the wrap.
REQ-026 PC=0005, ADDRin=1 and IncrPc=1 in the same cycle: ADDR=0005 and PC=0006 on the next cycle.
REQ-027 PC=FFFF, IncrPc=1: PC=0000 on the next cycle; PCin=1 with BusWires=0042 together with IncrPc=1: PC=0042.
REQ-028 DIN=0x1CB, IRin=1 in EXEC: Instrucao=0x1CB on the next cycle; the same stimulus in IDLE leaves Instrucao unchanged.
REQ-029 Done=1 with Clear=1 while Run=1: InstrCount +1, Tstep=00, state stays EXEC; repeated with Run=0: state goes to IDLE and Busy=0.
REQ-030 Resetn=0 at Tstep=10 with PC=0010: all outputs are 0 on the next cycle; Run held high after reset does not start execution until it has toggled 0->1.
